// File: rtl/seven_segment_decoder.sv
// Recovers the hex digit from an active-low 7-segment bus once the pattern has been stable for STABLE_CYCLES clocks.
// Optional saturating illegal-pattern counter is enabled by defining SEG_DECODE_ERR_COUNT_EN.
module seven_segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_seg_A,
  input  logic       i_seg_B,
  input  logic       i_seg_C,
  input  logic       i_seg_D,
  input  logic       i_seg_E,
  input  logic       i_seg_F,
  input  logic       i_seg_G,
  output logic [3:0] o_value,
  output logic       o_valid,
  output logic       o_new,
  output logic       o_blank,
  output logic       o_err
`ifdef SEG_DECODE_ERR_COUNT_EN
  ,
  input  logic       i_err_clr,
  output logic [7:0] o_err_count
`endif
);

  localparam int unsigned     CW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST      = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0]      SEG_BLANK = '1;

  typedef enum logic {ST_WAIT, ST_LOCKED} state_t;

  state_t        state, state_nxt;
  logic [6:0]    seg_in, r_seg;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          have_prev, have_prev_nxt;
  logic [3:0]    value_nxt;
  logic          valid_nxt, new_nxt, blank_nxt, err_nxt;
  logic          dec_ok;
  logic [3:0]    dec_val;

  assign seg_in = {i_seg_A, i_seg_B, i_seg_C, i_seg_D, i_seg_E, i_seg_F, i_seg_G};

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = '0;
    case (r_seg)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0001100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // r_seg equals seg_in whenever the lock branch is taken, so decoding the register is equivalent.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    have_prev_nxt = have_prev;
    value_nxt     = o_value;
    valid_nxt     = o_valid;
    blank_nxt     = o_blank;
    new_nxt       = 1'b0;
    err_nxt       = 1'b0;
    if (seg_in != r_seg) begin
      state_nxt = ST_WAIT;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
      blank_nxt = 1'b0;
    end else if (state == ST_WAIT) begin
      if (cnt < LAST) begin
        cnt_nxt = cnt + CW'(1);
      end else begin
        state_nxt = ST_LOCKED;
        if (dec_ok) begin
          value_nxt     = dec_val;
          valid_nxt     = 1'b1;
          blank_nxt     = 1'b0;
          new_nxt       = !have_prev || (dec_val != o_value);
          have_prev_nxt = 1'b1;
        end else if (r_seg == SEG_BLANK) begin
          valid_nxt = 1'b0;
          blank_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b0;
          blank_nxt = 1'b0;
          err_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_WAIT;
      r_seg     <= SEG_BLANK;
      cnt       <= '0;
      have_prev <= 1'b0;
      o_value   <= '0;
      o_valid   <= 1'b0;
      o_new     <= 1'b0;
      o_blank   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      r_seg     <= seg_in;
      cnt       <= cnt_nxt;
      have_prev <= have_prev_nxt;
      o_value   <= value_nxt;
      o_valid   <= valid_nxt;
      o_new     <= new_nxt;
      o_blank   <= blank_nxt;
      o_err     <= err_nxt;
    end
  end

`ifdef SEG_DECODE_ERR_COUNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_count <= '0;
    end else if (i_err_clr) begin
      o_err_count <= '0;
    end else if (err_nxt && (o_err_count != '1)) begin
      o_err_count <= o_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Randomized self-checking bench for seven_segment_decoder against a run-length reference model.
// Covers the SEG_DECODE_ERR_COUNT_EN counter when that macro is defined.
module tb_seven_segment_decoder;

  localparam int S = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] o_value;
  logic       o_valid, o_new, o_blank, o_err;
`ifdef SEG_DECODE_ERR_COUNT_EN
  logic       i_err_clr = 1'b0;
  logic [7:0] o_err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_decoder #(.STABLE_CYCLES(S)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_seg_A (seg[6]),
    .i_seg_B (seg[5]),
    .i_seg_C (seg[4]),
    .i_seg_D (seg[3]),
    .i_seg_E (seg[2]),
    .i_seg_F (seg[1]),
    .i_seg_G (seg[0]),
    .o_value (o_value),
    .o_valid (o_valid),
    .o_new   (o_new),
    .o_blank (o_blank),
    .o_err   (o_err)
`ifdef SEG_DECODE_ERR_COUNT_EN
    ,
    .i_err_clr   (i_err_clr),
    .o_err_count (o_err_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model: run length of the current sample decides lock; a lock fires when the run reaches S+1.
  logic [6:0]  m_last;
  int          m_run;
  logic [3:0]  m_value;
  logic        m_have;
  logic        e_valid, e_new, e_blank, e_err;
  int          m_errcnt;

  function automatic int find_digit(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 7'h7F; m_run = 1; m_value = 4'h0; m_have = 1'b0;
    e_valid = 1'b0; e_new = 1'b0; e_blank = 1'b0; e_err = 1'b0;
    m_errcnt = 0;
  endtask

  task automatic drive_edge(input logic [6:0] p);
    int  d;
    logic just;
    @(negedge i_clk);
    seg = p;
    @(posedge i_clk);
    just = 1'b0;
    if (p != m_last) begin
      m_last = p; m_run = 1;
    end else if (m_run <= S) begin
      m_run++;
      just = (m_run == S + 1);
    end
    d = find_digit(p);
    e_new = 1'b0; e_err = 1'b0;
    if (m_run == S + 1) begin
      e_valid = (d >= 0);
      e_blank = (p == 7'h7F);
      if (just) begin
        if (d >= 0) begin
          e_new   = !m_have || (m_value != 4'(d));
          m_value = 4'(d);
          m_have  = 1'b1;
        end else if (p != 7'h7F) begin
          e_err = 1'b1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
    end else begin
      e_valid = 1'b0; e_blank = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < S + 2; i++) begin
      drive_edge(7'h7F);
      n_checks++;
      if ({o_value, o_valid, o_new, o_blank, o_err} !== {m_value, e_valid, e_new, e_blank, e_err}) begin
        n_fail++;
        $display("FAIL reset_blank edge %0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, o_value, o_valid, o_new, o_blank, o_err, m_value, e_valid, e_new, e_blank, e_err);
      end
    end
    n_checks++;
    if ({o_blank, o_valid, o_new, o_value} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_blank_final: got blank=%b valid=%b new=%b value=%h want 1 0 0 0", o_blank, o_valid, o_new, o_value);
    end
  endtask

  task automatic test_latency();
    int news = 0;
    for (int i = 0; i < S + 3; i++) begin
      drive_edge(7'b0000110);
      news += int'(o_new);
      n_checks++;
      if ({o_value, o_valid, o_new, o_blank, o_err} !== {m_value, e_valid, e_new, e_blank, e_err}) begin
        n_fail++;
        $display("FAIL latency edge k+%0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, o_value, o_valid, o_new, o_blank, o_err, m_value, e_valid, e_new, e_blank, e_err);
      end
      if (i == S) begin
        n_checks++;
        if ({o_value, o_valid, o_new} !== {4'h3, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL latency_lock: got value=%h valid=%b new=%b want 3 1 1", o_value, o_valid, o_new);
        end
      end
    end
    n_checks++;
    if (news != 1) begin
      n_fail++;
      $display("FAIL latency_new_count: got %0d want 1", news);
    end
  endtask

  task automatic test_sweep();
    int news = 0, errs = 0;
    for (int d = 0; d < 16; d++) begin
      for (int c = 0; c < 6; c++) begin
        drive_edge(seg_tab[d]);
        news += int'(o_new);
        errs += int'(o_err);
        n_checks++;
        if ({o_value, o_valid, o_new, o_blank, o_err} !== {m_value, e_valid, e_new, e_blank, e_err}) begin
          n_fail++;
          $display("FAIL sweep digit %0d cyc %0d: got %h/%b%b%b%b want %h/%b%b%b%b", d, c, o_value, o_valid, o_new, o_blank, o_err, m_value, e_valid, e_new, e_blank, e_err);
        end
      end
      n_checks++;
      if (o_value !== 4'(d)) begin
        n_fail++;
        $display("FAIL sweep_value: got %h want %h", o_value, 4'(d));
      end
    end
    n_checks++;
    if (news != 16 || errs != 0) begin
      n_fail++;
      $display("FAIL sweep_pulses: got new=%0d err=%0d want 16 0", news, errs);
    end
  endtask

  task automatic test_glitch();
    logic [6:0] pat [$];
    int news = 0;
    pat = {};
    repeat (6) pat.push_back(7'b0000110);
    repeat (2) pat.push_back(7'b0000000);
    repeat (6) pat.push_back(7'b0000110);
    foreach (pat[i]) begin
      drive_edge(pat[i]);
      if (i >= 6) news += int'(o_new);
      n_checks++;
      if ({o_value, o_valid, o_new, o_blank, o_err} !== {m_value, e_valid, e_new, e_blank, e_err}) begin
        n_fail++;
        $display("FAIL glitch step %0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, o_value, o_valid, o_new, o_blank, o_err, m_value, e_valid, e_new, e_blank, e_err);
      end
      if (i == 6) begin
        n_checks++;
        if (o_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_drop: got valid=%b want 0", o_valid);
        end
      end
    end
    n_checks++;
    if (news != 0 || o_value !== 4'h3 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_relock: got new=%0d value=%h valid=%b want 0 3 1", news, o_value, o_valid);
    end
    news = 0;
    for (int i = 0; i < S + 1; i++) begin
      drive_edge(7'b0000000);
      news += int'(o_new);
    end
    n_checks++;
    if (news != 1 || o_value !== 4'h8) begin
      n_fail++;
      $display("FAIL glitch_long: got new=%0d value=%h want 1 8", news, o_value);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] held;
    int errs = 0;
    held = m_value;
    for (int i = 0; i < S + 3; i++) begin
      drive_edge(7'b1111110);
      errs += int'(o_err);
      n_checks++;
      if ({o_value, o_valid, o_new, o_blank, o_err} !== {m_value, e_valid, e_new, e_blank, e_err}) begin
        n_fail++;
        $display("FAIL illegal edge %0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, o_value, o_valid, o_new, o_blank, o_err, m_value, e_valid, e_new, e_blank, e_err);
      end
    end
    n_checks++;
    if (errs != 1 || o_valid !== 1'b0 || o_value !== held) begin
      n_fail++;
      $display("FAIL illegal_summary: got err=%0d valid=%b value=%h want 1 0 %h", errs, o_valid, o_value, held);
    end
  endtask

  task automatic test_random();
    logic [6:0] p;
    int sel, hold;
    p = 7'h7F;
    for (int seg_i = 0; seg_i < 80; seg_i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) p = seg_tab[$urandom_range(0, 15)];
      else if (sel == 6) p = 7'h7F;
      else if (sel == 7) begin
        p = 7'($urandom);
        while (find_digit(p) >= 0 || p == 7'h7F) p = 7'($urandom);
      end
      hold = int'($urandom_range(1, 7));
      for (int c = 0; c < hold; c++) begin
        drive_edge(p);
        n_checks++;
        if ({o_value, o_valid, o_new, o_blank, o_err} !== {m_value, e_valid, e_new, e_blank, e_err} || (o_new && o_err)) begin
          n_fail++;
          $display("FAIL random p=%b: got %h/%b%b%b%b want %h/%b%b%b%b", p, o_value, o_valid, o_new, o_blank, o_err, m_value, e_valid, e_new, e_blank, e_err);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int news = 0;
    for (int i = 0; i < S + 2; i++) drive_edge(7'b0100100);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_value, o_valid, o_new, o_blank, o_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%b%b%b%b want 0/0000", o_value, o_valid, o_new, o_blank, o_err);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < S + 2; i++) begin
      drive_edge(7'b0100100);
      news += int'(o_new);
      n_checks++;
      if ({o_value, o_valid, o_new, o_blank, o_err} !== {m_value, e_valid, e_new, e_blank, e_err}) begin
        n_fail++;
        $display("FAIL post_reset edge %0d: got %h/%b%b%b%b want %h/%b%b%b%b", i, o_value, o_valid, o_new, o_blank, o_err, m_value, e_valid, e_new, e_blank, e_err);
      end
    end
    n_checks++;
    if (news != 1 || o_value !== 4'h5) begin
      n_fail++;
      $display("FAIL post_reset_new: got new=%0d value=%h want 1 5", news, o_value);
    end
  endtask

`ifdef SEG_DECODE_ERR_COUNT_EN
  task automatic test_err_count();
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < S + 1; c++) drive_edge(7'h7F);
      for (int c = 0; c < S + 1; c++) drive_edge(7'b1111110);
    end
    n_checks++;
    if (o_err_count !== 8'(m_errcnt) || m_errcnt != 255) begin
      n_fail++;
      $display("FAIL err_count_sat: got %0d want 255 (model %0d)", o_err_count, m_errcnt);
    end
    for (int c = 0; c < S + 1; c++) drive_edge(7'h7F);
    i_err_clr = 1'b1;
    drive_edge(7'h7F);
    i_err_clr = 1'b0;
    n_checks++;
    if (o_err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_count_clr: got %0d want 0", o_err_count);
    end
    for (int c = 0; c < S; c++) drive_edge(7'b1111110);
    i_err_clr = 1'b1;
    drive_edge(7'b1111110);
    i_err_clr = 1'b0;
    n_checks++;
    if (o_err !== 1'b1 || o_err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_count_clr_priority: got err=%b count=%0d want 1 0", o_err, o_err_count);
    end
  endtask
`endif

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    test_reset();
    test_latency();
    test_sweep();
    test_glitch();
    test_illegal();
    test_random();
    test_async_reset();
`ifdef SEG_DECODE_ERR_COUNT_EN
    test_err_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
